ysyx_23060184_exu_sequencer: RTL and testbench

- Multi-cycle control FSM for the NPC execute datapath.
- Accepts one decoded instruction class per handshake from the IDU.
- Sequences it through EXEC / MEM / WB.
- Drives the ResultSrc, ALUSrcA and ALUSrcB mux selects, the register-file, CSR and PC write enables, and the LSU request handshake.
- Stops on ebreak, on an illegal instruction, or on an LSU timeout.

---
 rtl/ysyx_23060184_exu_pkg.sv | 74 +++++++
 rtl/ysyx_23060184_exu_ctrl_decode.sv | 90 +++++++++
 rtl/ysyx_23060184_exu_sequencer.sv | 144 ++++++++++++++
 tb/tb_ysyx_23060184_exu_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_exu_pkg.sv
// Shared encodings for the NPC execute sequencer: mux selects, instruction
// classes, FSM states and the per-class control bundle.
package ysyx_23060184_exu_pkg;

    localparam int RESULT_SRC_LENGTH = 2;
    localparam int ALU_SRCA_LENGTH   = 2;
    localparam int ALU_SRCB_LENGTH   = 2;

    localparam logic [RESULT_SRC_LENGTH-1:0] RESULT_SRC_PCPLUS4 = 2'b00;
    localparam logic [RESULT_SRC_LENGTH-1:0] RESULT_SRC_ALU     = 2'b01;
    localparam logic [RESULT_SRC_LENGTH-1:0] RESULT_SRC_MEM     = 2'b10;
    localparam logic [RESULT_SRC_LENGTH-1:0] RESULT_SRC_CSR     = 2'b11;

    localparam logic [ALU_SRCA_LENGTH-1:0] ALU_SRCA_PC   = 2'b00;
    localparam logic [ALU_SRCA_LENGTH-1:0] ALU_SRCA_RD1  = 2'b01;
    localparam logic [ALU_SRCA_LENGTH-1:0] ALU_SRCA_ZERO = 2'b10;

    localparam logic [ALU_SRCB_LENGTH-1:0] ALU_SRCB_IMM  = 2'b00;
    localparam logic [ALU_SRCB_LENGTH-1:0] ALU_SRCB_RD2  = 2'b01;
    localparam logic [ALU_SRCB_LENGTH-1:0] ALU_SRCB_CSR  = 2'b10;
    localparam logic [ALU_SRCB_LENGTH-1:0] ALU_SRCB_ZERO = 2'b11;

    localparam logic [3:0] INST_TYPE_R       = 4'd0;
    localparam logic [3:0] INST_TYPE_IALU    = 4'd1;
    localparam logic [3:0] INST_TYPE_LUI     = 4'd2;
    localparam logic [3:0] INST_TYPE_AUIPC   = 4'd3;
    localparam logic [3:0] INST_TYPE_LOAD    = 4'd4;
    localparam logic [3:0] INST_TYPE_STORE   = 4'd5;
    localparam logic [3:0] INST_TYPE_BRANCH  = 4'd6;
    localparam logic [3:0] INST_TYPE_JAL     = 4'd7;
    localparam logic [3:0] INST_TYPE_JALR    = 4'd8;
    localparam logic [3:0] INST_TYPE_CSRRW   = 4'd9;
    localparam logic [3:0] INST_TYPE_CSRRS   = 4'd10;
    localparam logic [3:0] INST_TYPE_EBREAK  = 4'd11;
    localparam logic [3:0] INST_TYPE_ILLEGAL = 4'd15;

    localparam logic [1:0] HALT_CAUSE_NONE    = 2'b00;
    localparam logic [1:0] HALT_CAUSE_EBREAK  = 2'b01;
    localparam logic [1:0] HALT_CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] HALT_CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MEM  = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } exu_state_e;

    typedef struct packed {
        logic [RESULT_SRC_LENGTH-1:0] result_src;
        logic [ALU_SRCA_LENGTH-1:0]   alu_srca;
        logic [ALU_SRCB_LENGTH-1:0]   alu_srcb;
        logic                         reg_we;
        logic                         csr_we;
        logic                         jump;
        logic                         branch;
        logic                         mem;
        logic                         store;
        logic                         ebreak;
        logic                         illegal;
    } exu_ctrl_t;

    // Quiescent bundle: what the datapath sees outside of an instruction.
    function automatic exu_ctrl_t ctrl_idle();
        exu_ctrl_t c;
        c            = '0;
        c.result_src = RESULT_SRC_ALU;
        c.alu_srca   = ALU_SRCA_ZERO;
        c.alu_srcb   = ALU_SRCB_ZERO;
        return c;
    endfunction

endpackage

// File: rtl/ysyx_23060184_exu_ctrl_decode.sv
// Combinational table from instruction class to datapath selects and
// write/flow flags; unknown codes decode as illegal.
module ysyx_23060184_exu_ctrl_decode
    import ysyx_23060184_exu_pkg::*;
#(
    parameter int TYPE_WIDTH = 4
) (
    input  logic [TYPE_WIDTH-1:0] inst_type,
    output exu_ctrl_t             ctrl
);

    always_comb begin
        ctrl = ctrl_idle();
        case (inst_type)
            TYPE_WIDTH'(INST_TYPE_R): begin
                ctrl.alu_srca = ALU_SRCA_RD1;
                ctrl.alu_srcb = ALU_SRCB_RD2;
                ctrl.reg_we   = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_IALU): begin
                ctrl.alu_srca = ALU_SRCA_RD1;
                ctrl.alu_srcb = ALU_SRCB_IMM;
                ctrl.reg_we   = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_LUI): begin
                ctrl.alu_srca = ALU_SRCA_ZERO;
                ctrl.alu_srcb = ALU_SRCB_IMM;
                ctrl.reg_we   = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_AUIPC): begin
                ctrl.alu_srca = ALU_SRCA_PC;
                ctrl.alu_srcb = ALU_SRCB_IMM;
                ctrl.reg_we   = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_LOAD): begin
                ctrl.alu_srca   = ALU_SRCA_RD1;
                ctrl.alu_srcb   = ALU_SRCB_IMM;
                ctrl.result_src = RESULT_SRC_MEM;
                ctrl.reg_we     = 1'b1;
                ctrl.mem        = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_STORE): begin
                ctrl.alu_srca = ALU_SRCA_RD1;
                ctrl.alu_srcb = ALU_SRCB_IMM;
                ctrl.mem      = 1'b1;
                ctrl.store    = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_BRANCH): begin
                ctrl.alu_srca = ALU_SRCA_RD1;
                ctrl.alu_srcb = ALU_SRCB_RD2;
                ctrl.branch   = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_JAL): begin
                ctrl.alu_srca   = ALU_SRCA_PC;
                ctrl.alu_srcb   = ALU_SRCB_IMM;
                ctrl.result_src = RESULT_SRC_PCPLUS4;
                ctrl.reg_we     = 1'b1;
                ctrl.jump       = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_JALR): begin
                ctrl.alu_srca   = ALU_SRCA_RD1;
                ctrl.alu_srcb   = ALU_SRCB_IMM;
                ctrl.result_src = RESULT_SRC_PCPLUS4;
                ctrl.reg_we     = 1'b1;
                ctrl.jump       = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_CSRRW): begin
                ctrl.alu_srca   = ALU_SRCA_ZERO;
                ctrl.alu_srcb   = ALU_SRCB_CSR;
                ctrl.result_src = RESULT_SRC_CSR;
                ctrl.reg_we     = 1'b1;
                ctrl.csr_we     = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_CSRRS): begin
                ctrl.alu_srca   = ALU_SRCA_RD1;
                ctrl.alu_srcb   = ALU_SRCB_CSR;
                ctrl.result_src = RESULT_SRC_CSR;
                ctrl.reg_we     = 1'b1;
                ctrl.csr_we     = 1'b1;
            end
            TYPE_WIDTH'(INST_TYPE_EBREAK): begin
                ctrl.ebreak = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060184_exu_sequencer.sv
// Multi-cycle execute control FSM: IDLE -> EXEC -> [MEM] -> WB, with a sticky
// HALT on ebreak, illegal class or LSU timeout.
module ysyx_23060184_exu_sequencer
    import ysyx_23060184_exu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TYPE_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         inst_valid,
    input  logic [TYPE_WIDTH-1:0]        inst_type,
    output logic                         inst_ready,
    input  logic                         branch_taken,
    output logic                         lsu_req,
    output logic                         lsu_we,
    input  logic                         lsu_done,
    output logic [RESULT_SRC_LENGTH-1:0] result_src,
    output logic [ALU_SRCA_LENGTH-1:0]   alu_srca,
    output logic [ALU_SRCB_LENGTH-1:0]   alu_srcb,
    output logic                         reg_we,
    output logic                         csr_we,
    output logic                         pc_we,
    output logic                         pc_src,
    output logic                         retire,
    output logic                         halt,
    output logic [1:0]                   halt_cause
);

    localparam logic [7:0] TIMEOUT_COUNT = 8'(MEM_TIMEOUT);

    exu_state_e            state_q, state_d;
    logic [TYPE_WIDTH-1:0] type_q, type_d;
    logic                  taken_q, taken_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            cause_q, cause_d;
    logic [7:0]            cnt_inc;
    exu_ctrl_t             ctrl;

    ysyx_23060184_exu_ctrl_decode #(
        .TYPE_WIDTH (TYPE_WIDTH)
    ) u_ctrl_decode (
        .inst_type (type_q),
        .ctrl      (ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            taken_q <= 1'b0;
            cnt_q   <= 8'd0;
            cause_q <= HALT_CAUSE_NONE;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign inst_ready = (state_q == S_IDLE) && rstn;
    assign halt       = (state_q == S_HALT);
    assign halt_cause = cause_q;
    assign cnt_inc    = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        taken_d    = taken_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        result_src = RESULT_SRC_ALU;
        alu_srca   = ALU_SRCA_ZERO;
        alu_srcb   = ALU_SRCB_ZERO;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        reg_we     = 1'b0;
        csr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        retire     = 1'b0;

        // Selects come from the latched class and stay stable EXEC..WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            result_src = ctrl.result_src;
            alu_srca   = ctrl.alu_srca;
            alu_srcb   = ctrl.alu_srcb;
        end

        case (state_q)
            S_IDLE: begin
                if (inst_valid && inst_ready) begin
                    type_d  = inst_type;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d = branch_taken;
                if (ctrl.ebreak) begin
                    state_d = S_HALT;
                    cause_d = HALT_CAUSE_EBREAK;
                end else if (ctrl.illegal) begin
                    state_d = S_HALT;
                    cause_d = HALT_CAUSE_ILLEGAL;
                end else if (ctrl.mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_we  = ctrl.store;
                cnt_d   = cnt_inc;
                // A completion in the same cycle as the timeout still wins.
                if (lsu_done) begin
                    state_d = S_WB;
                    cnt_d   = 8'd0;
                end else if (cnt_inc == TIMEOUT_COUNT) begin
                    state_d = S_HALT;
                    cause_d = HALT_CAUSE_TIMEOUT;
                    cnt_d   = 8'd0;
                end
            end
            S_WB: begin
                reg_we  = ctrl.reg_we;
                csr_we  = ctrl.csr_we;
                pc_we   = 1'b1;
                pc_src  = ctrl.jump | (ctrl.branch & taken_q);
                retire  = 1'b1;
                state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060184_exu_sequencer.sv
// Directed bench for the execute sequencer: class table, memory wait and
// timeout, branches, halts and mid-instruction reset.
module tb_ysyx_23060184_exu_sequencer;

    logic       clk;
    logic       rstn;
    logic       inst_valid;
    logic [3:0] inst_type;
    logic       branch_taken;
    logic       lsu_done;

    logic       inst_ready, lsu_req, lsu_we, reg_we, csr_we, pc_we, pc_src, retire, halt;
    logic [1:0] result_src, alu_srca, alu_srcb, halt_cause;

    logic       t_inst_ready, t_lsu_req, t_lsu_we, t_reg_we, t_csr_we, t_pc_we, t_pc_src, t_retire, t_halt;
    logic [1:0] t_result_src, t_alu_srca, t_alu_srcb, t_halt_cause;

    int checks = 0;
    int errors = 0;

    ysyx_23060184_exu_sequencer #(.MEM_TIMEOUT(255), .TYPE_WIDTH(4)) dut (
        .clk(clk), .rstn(rstn), .inst_valid(inst_valid), .inst_type(inst_type),
        .inst_ready(inst_ready), .branch_taken(branch_taken), .lsu_req(lsu_req),
        .lsu_we(lsu_we), .lsu_done(lsu_done), .result_src(result_src),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .reg_we(reg_we), .csr_we(csr_we),
        .pc_we(pc_we), .pc_src(pc_src), .retire(retire), .halt(halt),
        .halt_cause(halt_cause)
    );

    ysyx_23060184_exu_sequencer #(.MEM_TIMEOUT(4), .TYPE_WIDTH(4)) dut_to (
        .clk(clk), .rstn(rstn), .inst_valid(inst_valid), .inst_type(inst_type),
        .inst_ready(t_inst_ready), .branch_taken(branch_taken), .lsu_req(t_lsu_req),
        .lsu_we(t_lsu_we), .lsu_done(lsu_done), .result_src(t_result_src),
        .alu_srca(t_alu_srca), .alu_srcb(t_alu_srcb), .reg_we(t_reg_we), .csr_we(t_csr_we),
        .pc_we(t_pc_we), .pc_src(t_pc_src), .retire(t_retire), .halt(t_halt),
        .halt_cause(t_halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn       = 1'b0;
        inst_valid = 1'b0;
        lsu_done   = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Presents one instruction in IDLE; returns at the negedge of its EXEC cycle.
    task automatic send(input logic [3:0] t);
        @(negedge clk);
        inst_valid = 1'b1;
        inst_type  = t;
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0] t;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic       rw;
        logic       cw;
        logic       ps;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'd0,  2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};  // R
        vecs[1] = '{4'd1,  2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};  // IALU
        vecs[2] = '{4'd2,  2'b10, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};  // LUI
        vecs[3] = '{4'd3,  2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};  // AUIPC
        vecs[4] = '{4'd7,  2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};  // JAL
        vecs[5] = '{4'd8,  2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};  // JALR
        vecs[6] = '{4'd9,  2'b10, 2'b10, 2'b11, 1'b1, 1'b1, 1'b0};  // CSRRW
        vecs[7] = '{4'd10, 2'b01, 2'b10, 2'b11, 1'b1, 1'b1, 1'b0};  // CSRRS

        rstn = 1'b0; inst_valid = 1'b0; inst_type = 4'd0;
        branch_taken = 1'b0; lsu_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_inst_ready", inst_ready, 0);
        check("rst_result_src", result_src, 2'b01);
        check("rst_srca", alu_srca, 2'b10);
        check("rst_srcb", alu_srcb, 2'b11);
        check("rst_enables", {lsu_req, reg_we, csr_we, pc_we, retire}, 0);
        check("rst_halt", {halt, halt_cause}, 0);
        rstn = 1'b1;

        // R-type with inst_valid held high
        @(negedge clk);
        check("r_ready_c0", inst_ready, 1);
        inst_valid = 1'b1; inst_type = 4'd0;
        @(negedge clk);
        check("r_ready_c1", inst_ready, 0);
        check("r_srca_c1", alu_srca, 2'b01);
        check("r_srcb_c1", alu_srcb, 2'b01);
        @(negedge clk);
        check("r_ready_c2", inst_ready, 0);
        check("r_wb", {reg_we, pc_we, retire, result_src}, {3'b111, 2'b01});
        @(negedge clk);
        check("r_ready_c3", inst_ready, 1);
        inst_valid = 1'b0;
        $display("txn R held-valid retired");

        // Class table for non-memory instructions
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].t);
            check($sformatf("cls%0d_srca", vecs[i].t), alu_srca, vecs[i].a);
            check($sformatf("cls%0d_srcb", vecs[i].t), alu_srcb, vecs[i].b);
            @(negedge clk);
            check($sformatf("cls%0d_res", vecs[i].t), result_src, vecs[i].res);
            check($sformatf("cls%0d_we", vecs[i].t), {reg_we, csr_we, pc_we, pc_src, retire},
                  {vecs[i].rw, vecs[i].cw, 1'b1, vecs[i].ps, 1'b1});
            $display("txn class %0d retired", vecs[i].t);
        end

        // LOAD with lsu_done in the 5th MEM cycle
        send(4'd4);
        check("ld_exec_sel", {alu_srca, alu_srcb}, {2'b01, 2'b00});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("ld_mem%0d_req", i), {lsu_req, lsu_we, retire}, 3'b100);
            if (i == 4) lsu_done = 1'b1;
        end
        @(negedge clk);
        lsu_done = 1'b0;
        check("ld_wb", {reg_we, retire, lsu_req, result_src}, {3'b110, 2'b10});
        $display("txn LOAD retired after 5 LSU cycles");
        do_reset();

        // STORE
        send(4'd5);
        @(negedge clk);
        check("st_mem", {lsu_req, lsu_we}, 2'b11);
        lsu_done = 1'b1;
        @(negedge clk);
        lsu_done = 1'b0;
        check("st_wb", {reg_we, pc_we, retire, lsu_req}, 4'b0110);
        $display("txn STORE retired");

        // BRANCH taken then not taken; input flipped after EXEC to prove latching
        send(4'd6);
        branch_taken = 1'b1;
        @(negedge clk);
        branch_taken = 1'b0;
        check("br1_wb", {reg_we, pc_we, pc_src}, 3'b011);
        send(4'd6);
        branch_taken = 1'b0;
        @(negedge clk);
        branch_taken = 1'b1;
        check("br0_wb", {reg_we, pc_we, pc_src}, 3'b010);
        branch_taken = 1'b0;
        $display("txn BRANCH x2 retired");

        // Timeout on the MEM_TIMEOUT=4 instance
        do_reset();
        send(4'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("to_mem%0d", i), {t_lsu_req, t_halt, t_reg_we}, 3'b100);
        end
        @(negedge clk);
        check("to_halt", {t_halt, t_halt_cause}, {1'b1, 2'b11});
        check("to_quiet", {t_reg_we, t_retire, t_lsu_req, t_inst_ready}, 0);
        @(negedge clk);
        check("to_sticky", {t_halt, t_inst_ready}, 2'b10);
        $display("txn LOAD timed out");

        // lsu_done exactly at count 4 wins over the timeout
        do_reset();
        send(4'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) lsu_done = 1'b1;
        end
        @(negedge clk);
        lsu_done = 1'b0;
        check("edge_wb", {t_halt, t_retire, t_reg_we, t_result_src}, {3'b011, 2'b10});
        $display("txn LOAD completed on timeout edge");

        // EBREAK, then a further instruction is ignored
        do_reset();
        send(4'd11);
        @(negedge clk);
        check("eb_halt", {halt, halt_cause, retire, inst_ready}, {1'b1, 2'b01, 2'b00});
        inst_valid = 1'b1; inst_type = 4'd13;
        repeat (2) @(negedge clk);
        check("eb_sticky", {halt, halt_cause, retire, inst_ready, reg_we}, {1'b1, 2'b01, 3'b000});
        inst_valid = 1'b0;
        $display("txn EBREAK halted");

        // Unlisted code after reset
        do_reset();
        check("ill_cleared", {halt, halt_cause}, 0);
        send(4'd13);
        @(negedge clk);
        check("ill_halt", {halt, halt_cause, retire}, {1'b1, 2'b10, 1'b0});
        $display("txn type 13 halted as illegal");

        // Reset in the middle of S_MEM
        do_reset();
        send(4'd4);
        repeat (2) @(negedge clk);
        check("mr_in_mem", lsu_req, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("mr_abort", {lsu_req, reg_we, retire, inst_ready, halt}, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("mr_idle", inst_ready, 1);
        $display("txn LOAD aborted by reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
